bank_latency_stats_collector: RTL and testbench

Per-bank request latency statistics engine; the synthesizable successor to the per-bank CSV response logger.
- Tracks up to MAX_OUTSTANDING in-flight requests by ID.
- Computes issue-to-response latency on each matching response and accumulates read/write counts, latency sum/min/max and a latency histogram.
- Counters are readable through a registered select port.
- Sits beside each bank scheduler, snooping its request-accept and response-fire strobes.

---
 rtl/perf_stats_pkg.sv | 30 +++
 rtl/latency_tag_table.sv | 127 ++++++++++++
 rtl/bank_latency_stats_collector.sv | 187 ++++++++++++++++++
 tb/tb_bank_latency_stats_collector.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_stats_pkg.sv
// rtl/perf_stats_pkg.sv - stat_sel encoding, tracking-entry type and saturating increment
package perf_stats_pkg;

  // stat_sel encoding; histogram bins follow contiguously from STAT_HIST_BASE
  localparam int STAT_RD_CNT     = 0;
  localparam int STAT_WR_CNT     = 1;
  localparam int STAT_LAT_SUM_LO = 2;
  localparam int STAT_LAT_SUM_HI = 3;
  localparam int STAT_LAT_MIN    = 4;
  localparam int STAT_LAT_MAX    = 5;
  localparam int STAT_ORPHAN_CNT = 6;
  localparam int STAT_DROP_CNT   = 7;
  localparam int STAT_HIST_BASE  = 8;

  localparam int TS_W = 64;

  // One tracking-table entry. The request ID lives in a parallel array so that
  // ID_W can stay a module parameter.
  typedef struct packed {
    logic            valid;
    logic            is_write;
    logic [TS_W-1:0] start_cycle;
  } tag_entry_t;

  // Increment that sticks at max_value instead of wrapping
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input logic [63:0] max_value);
    return (value >= max_value) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/latency_tag_table.sv
// rtl/latency_tag_table.sv - in-flight request table: priority allocate, ID match, stage-1 latency
module latency_tag_table
  import perf_stats_pkg::*;
#(
  parameter int ID_W            = 32,
  parameter int MAX_OUTSTANDING = 8,
  parameter int OCC_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req_fire,
  input  logic [ID_W-1:0]  i_req_id,
  input  logic             i_req_is_write,
  input  logic             i_resp_fire,
  input  logic [ID_W-1:0]  i_resp_id,
  input  logic [TS_W-1:0]  i_cycle,
  output logic             o_drop,
  output logic             o_orphan,
  output logic             o_s1_valid,
  output logic             o_s1_is_write,
  output logic [TS_W-1:0]  o_s1_latency,
  output logic [ID_W-1:0]  o_s1_id,
  output logic [TS_W-1:0]  o_s1_start,
  output logic [OCC_W-1:0] o_outstanding,
  output logic             o_table_full
);

  localparam int IDX_W = $clog2(MAX_OUTSTANDING);

  tag_entry_t                 r_tab [MAX_OUTSTANDING];
  logic [ID_W-1:0]            r_id  [MAX_OUTSTANDING];
  logic                       r_s1_valid;
  logic                       r_s1_is_write;
  logic [TS_W-1:0]            r_s1_latency;
  logic [ID_W-1:0]            r_s1_id;
  logic [TS_W-1:0]            r_s1_start;
  logic [OCC_W-1:0]           r_outstanding;
  logic                       r_table_full;

  logic                       w_any_free;
  logic                       w_any_match;
  logic [IDX_W-1:0]           w_free_idx;
  logic [IDX_W-1:0]           w_match_idx;
  logic [MAX_OUTSTANDING-1:0] w_valid_next;
  logic [OCC_W-1:0]           w_count_next;

  // Priority encoders over the pre-edge table; scanning downward leaves the lowest index
  always_comb begin
    w_any_free  = 1'b0;
    w_free_idx  = '0;
    w_any_match = 1'b0;
    w_match_idx = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (!r_tab[i].valid) begin
        w_any_free = 1'b1;
        w_free_idx = IDX_W'(i);
      end
      if (r_tab[i].valid && (r_id[i] == i_resp_id)) begin
        w_any_match = 1'b1;
        w_match_idx = IDX_W'(i);
      end
    end
  end

  // Post-edge valid vector, used only for the registered occupancy outputs
  always_comb begin
    w_valid_next = '0;
    w_count_next = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      w_valid_next[i] = r_tab[i].valid;
    end
    if (i_resp_fire && w_any_match) begin
      w_valid_next[w_match_idx] = 1'b0;
    end
    if (i_req_fire && w_any_free) begin
      w_valid_next[w_free_idx] = 1'b1;
    end
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      w_count_next = w_count_next + OCC_W'(w_valid_next[i]);
    end
  end

  assign o_drop   = i_req_fire  && !w_any_free;
  assign o_orphan = i_resp_fire && !w_any_match;

  // Retire the matched entry, fill the allocated slot and capture the stage-1 latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_tab[i] <= '0;
        r_id[i]  <= '0;
      end
      r_s1_valid    <= 1'b0;
      r_s1_is_write <= 1'b0;
      r_s1_latency  <= '0;
      r_s1_id       <= '0;
      r_s1_start    <= '0;
      r_outstanding <= '0;
      r_table_full  <= 1'b0;
    end else begin
      // The free slot was free before this edge and the matched slot was valid, so they never collide
      if (i_resp_fire && w_any_match) begin
        r_tab[w_match_idx].valid <= 1'b0;
        r_s1_is_write            <= r_tab[w_match_idx].is_write;
        r_s1_latency             <= i_cycle - r_tab[w_match_idx].start_cycle;
        r_s1_id                  <= r_id[w_match_idx];
        r_s1_start               <= r_tab[w_match_idx].start_cycle;
      end
      if (i_req_fire && w_any_free) begin
        r_tab[w_free_idx] <= '{valid: 1'b1, is_write: i_req_is_write, start_cycle: i_cycle};
        r_id[w_free_idx]  <= i_req_id;
      end
      r_s1_valid    <= i_resp_fire && w_any_match;
      r_outstanding <= w_count_next;
      r_table_full  <= &w_valid_next;
    end
  end

  assign o_s1_valid    = r_s1_valid;
  assign o_s1_is_write = r_s1_is_write;
  assign o_s1_latency  = r_s1_latency;
  assign o_s1_id       = r_s1_id;
  assign o_s1_start    = r_s1_start;
  assign o_outstanding = r_outstanding;
  assign o_table_full  = r_table_full;

endmodule

// File: rtl/bank_latency_stats_collector.sv
// rtl/bank_latency_stats_collector.sv - per-bank latency statistics; LATENCY_CSV_LOG_EN adds a sim-only CSV log
module bank_latency_stats_collector
  import perf_stats_pkg::*;
#(
  parameter int RANK            = 0,
  parameter int BANK            = 0,
  parameter int ID_W            = 32,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = 32,
  parameter int HIST_BINS       = 8,
  parameter int BIN_SHIFT       = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   req_fire,
  input  logic [ID_W-1:0]                        req_id,
  input  logic                                   req_is_write,
  input  logic                                   resp_fire,
  input  logic [ID_W-1:0]                        resp_id,
  input  logic [63:0]                            globalCycle,
  input  logic                                   clear,
  input  logic [7:0]                             stat_sel,
  output logic [CNT_W-1:0]                       stat_data,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   table_full,
  output logic                                   err_sticky
);

  localparam int               OCC_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam int               BIN_W     = $clog2(HIST_BINS);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [63:0]      CNT_MAX64 = 64'(CNT_MAX);

  logic             w_drop;
  logic             w_orphan;
  logic             w_s1_valid;
  logic             w_s1_is_write;
  logic [63:0]      w_s1_latency;
  logic [ID_W-1:0]  w_s1_id;
  logic [63:0]      w_s1_start;
  logic [CNT_W-1:0] w_lat_sat;
  logic [63:0]      w_bin_raw;
  logic [BIN_W-1:0] w_bin;
  logic [CNT_W-1:0] w_stat_mux;

  logic [CNT_W-1:0] r_rd_cnt;
  logic [CNT_W-1:0] r_wr_cnt;
  logic [63:0]      r_lat_sum;
  logic [CNT_W-1:0] r_lat_min;
  logic [CNT_W-1:0] r_lat_max;
  logic [CNT_W-1:0] r_orphan_cnt;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] r_hist [HIST_BINS];
  logic             r_err_sticky;
  logic [CNT_W-1:0] r_stat_data;

  latency_tag_table #(
    .ID_W            (ID_W),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .OCC_W           (OCC_W)
  ) u_tag_table (
    .clk            (clk),
    .rst_n          (reset),
    .i_req_fire     (req_fire),
    .i_req_id       (req_id),
    .i_req_is_write (req_is_write),
    .i_resp_fire    (resp_fire),
    .i_resp_id      (resp_id),
    .i_cycle        (globalCycle),
    .o_drop         (w_drop),
    .o_orphan       (w_orphan),
    .o_s1_valid     (w_s1_valid),
    .o_s1_is_write  (w_s1_is_write),
    .o_s1_latency   (w_s1_latency),
    .o_s1_id        (w_s1_id),
    .o_s1_start     (w_s1_start),
    .o_outstanding  (outstanding),
    .o_table_full   (table_full)
  );

  // Min/max track the latency clipped to counter width; the bin index clamps into the last bin
  always_comb begin
    w_lat_sat = (w_s1_latency > CNT_MAX64) ? CNT_MAX : w_s1_latency[CNT_W-1:0];
    w_bin_raw = w_s1_latency >> BIN_SHIFT;
    w_bin     = (w_bin_raw > 64'(HIST_BINS - 1)) ? BIN_W'(HIST_BINS - 1) : w_bin_raw[BIN_W-1:0];
  end

  // Stage-2 accumulators; clear takes priority over any same-cycle completion, drop or orphan
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_cnt     <= '0;
      r_wr_cnt     <= '0;
      r_lat_sum    <= '0;
      r_lat_min    <= CNT_MAX;
      r_lat_max    <= '0;
      r_orphan_cnt <= '0;
      r_drop_cnt   <= '0;
      r_err_sticky <= 1'b0;
      for (int b = 0; b < HIST_BINS; b++) r_hist[b] <= '0;
    end else if (clear) begin
      r_rd_cnt     <= '0;
      r_wr_cnt     <= '0;
      r_lat_sum    <= '0;
      r_lat_min    <= CNT_MAX;
      r_lat_max    <= '0;
      r_orphan_cnt <= '0;
      r_drop_cnt   <= '0;
      r_err_sticky <= 1'b0;
      for (int b = 0; b < HIST_BINS; b++) r_hist[b] <= '0;
    end else begin
      if (w_drop) begin
        r_drop_cnt   <= CNT_W'(sat_inc(64'(r_drop_cnt), CNT_MAX64));
        r_err_sticky <= 1'b1;
      end
      if (w_orphan) begin
        r_orphan_cnt <= CNT_W'(sat_inc(64'(r_orphan_cnt), CNT_MAX64));
        r_err_sticky <= 1'b1;
      end
      if (w_s1_valid) begin
        if (w_s1_is_write) begin
          r_wr_cnt <= CNT_W'(sat_inc(64'(r_wr_cnt), CNT_MAX64));
        end else begin
          r_rd_cnt <= CNT_W'(sat_inc(64'(r_rd_cnt), CNT_MAX64));
        end
        r_lat_sum <= r_lat_sum + w_s1_latency;
        if (w_lat_sat < r_lat_min) r_lat_min <= w_lat_sat;
        if (w_lat_sat > r_lat_max) r_lat_max <= w_lat_sat;
        r_hist[w_bin] <= CNT_W'(sat_inc(64'(r_hist[w_bin]), CNT_MAX64));
      end
    end
  end

  // Statistic select; unmapped codes read as zero
  always_comb begin
    w_stat_mux = '0;
    case (stat_sel)
      8'(STAT_RD_CNT):     w_stat_mux = r_rd_cnt;
      8'(STAT_WR_CNT):     w_stat_mux = r_wr_cnt;
      8'(STAT_LAT_SUM_LO): w_stat_mux = CNT_W'(r_lat_sum);
      8'(STAT_LAT_SUM_HI): w_stat_mux = CNT_W'(r_lat_sum >> CNT_W);
      8'(STAT_LAT_MIN):    w_stat_mux = r_lat_min;
      8'(STAT_LAT_MAX):    w_stat_mux = r_lat_max;
      8'(STAT_ORPHAN_CNT): w_stat_mux = r_orphan_cnt;
      8'(STAT_DROP_CNT):   w_stat_mux = r_drop_cnt;
      default: begin
        for (int b = 0; b < HIST_BINS; b++) begin
          if (stat_sel == 8'(STAT_HIST_BASE + b)) w_stat_mux = r_hist[b];
        end
      end
    endcase
  end

  // Registered readout: one cycle from stat_sel to stat_data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_data <= '0;
    end else begin
      r_stat_data <= w_stat_mux;
    end
  end

  assign stat_data  = r_stat_data;
  assign err_sticky = r_err_sticky;

`ifdef LATENCY_CSV_LOG_EN
  // Per-bank log header
  initial begin
    $display("latency_stats_rank%0d_bank%0d.csv: RequestID,Type,IssueCycle,RespCycle,Latency", RANK, BANK);
  end

  // One line per completion, drop and orphan
  always @(posedge clk) begin
    if (reset) begin
      if (w_s1_valid) begin
        $display("latency_stats_rank%0d_bank%0d.csv: %0d,%0d,%0d,%0d,%0d", RANK, BANK, w_s1_id,
                 w_s1_is_write, w_s1_start, w_s1_start + w_s1_latency, w_s1_latency);
      end
      if (w_drop)   $display("latency_stats_rank%0d_bank%0d.csv: DROP,%0d", RANK, BANK, req_id);
      if (w_orphan) $display("latency_stats_rank%0d_bank%0d.csv: ORPHAN,%0d", RANK, BANK, resp_id);
    end
  end
`else
  logic w_unused_log;
  assign w_unused_log = ^{w_s1_id, w_s1_start, 1'(RANK), 1'(BANK)};
`endif

endmodule

// File: tb/tb_bank_latency_stats_collector.sv
// tb/tb_bank_latency_stats_collector.sv - table-driven bench for bank_latency_stats_collector
module tb_bank_latency_stats_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_fire;
  logic [31:0] req_id;
  logic        req_is_write;
  logic        resp_fire;
  logic [31:0] resp_id;
  logic [63:0] gcyc;
  logic        clear;
  logic [7:0]  stat_sel;
  logic [31:0] stat_data;
  logic [3:0]  outstanding;
  logic        table_full;
  logic        err_sticky;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bank_latency_stats_collector dut (
    .clk          (clk),
    .reset        (reset),
    .req_fire     (req_fire),
    .req_id       (req_id),
    .req_is_write (req_is_write),
    .resp_fire    (resp_fire),
    .resp_id      (resp_id),
    .globalCycle  (gcyc),
    .clear        (clear),
    .stat_sel     (stat_sel),
    .stat_data    (stat_data),
    .outstanding  (outstanding),
    .table_full   (table_full),
    .err_sticky   (err_sticky)
  );

  typedef struct {
    int          phase;
    string       name;
    logic [7:0]  sel;
    logic [31:0] exp;
  } stat_vec_t;

  stat_vec_t vecs[$];

  function automatic void add(input int ph, input string nm, input logic [7:0] sel, input logic [31:0] exp);
    stat_vec_t v;
    v.phase = ph;
    v.name  = nm;
    v.sel   = sel;
    v.exp   = exp;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] id, input logic w, input logic [63:0] gc);
    req_fire = 1'b1; req_id = id; req_is_write = w; gcyc = gc;
    step();
    req_fire = 1'b0;
  endtask

  task automatic resp(input logic [31:0] id, input logic [63:0] gc);
    resp_fire = 1'b1; resp_id = id; gcyc = gc;
    step();
    resp_fire = 1'b0;
  endtask

  task automatic req_and_resp(input logic [31:0] rq, input logic [31:0] rs, input logic [63:0] gc);
    req_fire = 1'b1; req_id = rq; req_is_write = 1'b0;
    resp_fire = 1'b1; resp_id = rs; gcyc = gc;
    step();
    req_fire = 1'b0; resp_fire = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic run_phase(input int ph);
    step();
    step();
    foreach (vecs[k]) begin
      if (vecs[k].phase == ph) begin
        stat_sel = vecs[k].sel;
        step();
        check($sformatf("p%0d %s", ph, vecs[k].name), 64'(stat_data), 64'(vecs[k].exp));
      end
    end
  endtask

  initial begin
    // phase 0: reset values
    add(0, "rd_cnt", 8'd0, 32'd0);
    add(0, "lat_min", 8'd4, 32'hFFFF_FFFF);
    add(0, "lat_max", 8'd5, 32'd0);
    add(0, "hist0", 8'd8, 32'd0);
    // phase 1: read latency 12
    add(1, "rd_cnt", 8'd0, 32'd1);
    add(1, "wr_cnt", 8'd1, 32'd0);
    add(1, "sum_lo", 8'd2, 32'd12);
    add(1, "sum_hi", 8'd3, 32'd0);
    add(1, "lat_min", 8'd4, 32'd12);
    add(1, "lat_max", 8'd5, 32'd12);
    add(1, "hist3", 8'd11, 32'd1);
    add(1, "hist0", 8'd8, 32'd0);
    add(1, "sel16", 8'd16, 32'd0);
    add(1, "sel255", 8'd255, 32'd0);
    // phase 2: full table, two drops, one completion of latency 10
    add(2, "drop_cnt", 8'd7, 32'd2);
    add(2, "rd_cnt", 8'd0, 32'd1);
    add(2, "sum_lo", 8'd2, 32'd10);
    add(2, "lat_min", 8'd4, 32'd10);
    add(2, "hist2", 8'd10, 32'd1);
    add(2, "orphan", 8'd6, 32'd0);
    // phase 3: orphans and duplicate IDs (lowest entry matches first)
    add(3, "orphan", 8'd6, 32'd2);
    add(3, "rd_cnt", 8'd0, 32'd2);
    add(3, "sum_lo", 8'd2, 32'd35);
    add(3, "lat_min", 8'd4, 32'd15);
    add(3, "lat_max", 8'd5, 32'd20);
    add(3, "hist3", 8'd11, 32'd1);
    add(3, "hist5", 8'd13, 32'd1);
    add(3, "drop_cnt", 8'd7, 32'd0);
    // phase 4: read 100, writes 4 and 40
    add(4, "rd_cnt", 8'd0, 32'd1);
    add(4, "wr_cnt", 8'd1, 32'd2);
    add(4, "sum_lo", 8'd2, 32'd144);
    add(4, "lat_min", 8'd4, 32'd4);
    add(4, "lat_max", 8'd5, 32'd100);
    add(4, "hist7", 8'd15, 32'd2);
    add(4, "hist1", 8'd9, 32'd1);
    // phase 5: plus latency 2^32+5 (sum carry, max saturation)
    add(5, "rd_cnt", 8'd0, 32'd2);
    add(5, "sum_lo", 8'd2, 32'h95);
    add(5, "sum_hi", 8'd3, 32'd1);
    add(5, "lat_max", 8'd5, 32'hFFFF_FFFF);
    add(5, "lat_min", 8'd4, 32'd4);
    add(5, "hist7", 8'd15, 32'd3);
    // phase 6: clear beats same-cycle completion and orphan
    add(6, "rd_cnt", 8'd0, 32'd0);
    add(6, "sum_lo", 8'd2, 32'd0);
    add(6, "lat_min", 8'd4, 32'hFFFF_FFFF);
    add(6, "lat_max", 8'd5, 32'd0);
    add(6, "orphan", 8'd6, 32'd0);
    add(6, "hist2", 8'd10, 32'd0);
    add(6, "hist7", 8'd15, 32'd0);
    // phase 7: after mid-run reset, old IDs are orphans and the pending completion is lost
    add(7, "orphan", 8'd6, 32'd2);
    add(7, "rd_cnt", 8'd0, 32'd0);
    add(7, "sum_lo", 8'd2, 32'd0);
    add(7, "lat_min", 8'd4, 32'hFFFF_FFFF);
    add(7, "hist5", 8'd13, 32'd0);

    reset = 1'b0; req_fire = 1'b0; req_id = '0; req_is_write = 1'b0;
    resp_fire = 1'b0; resp_id = '0; gcyc = '0; clear = 1'b0; stat_sel = 8'd0;
    step();
    step();
    check("reset outstanding", 64'(outstanding), 64'd0);
    check("reset table_full", 64'(table_full), 64'd0);
    check("reset err_sticky", 64'(err_sticky), 64'd0);
    check("reset stat_data", 64'(stat_data), 64'd0);
    reset = 1'b1;
    run_phase(0);

    // phase 1
    stat_sel = 8'd0;
    req(32'd5, 1'b0, 64'd100);
    check("p1 outstanding after req", 64'(outstanding), 64'd1);
    resp(32'd5, 64'd112);
    check("p1 outstanding after resp", 64'(outstanding), 64'd0);
    step();
    check("p1 stat_data at +1", 64'(stat_data), 64'd0);
    step();
    check("p1 stat_data at +2", 64'(stat_data), 64'd1);
    run_phase(1);

    // phase 2
    do_clear();
    for (int i = 0; i < 8; i++) req(32'(10 + i), 1'b0, 64'(200 + i));
    check("p2 outstanding full", 64'(outstanding), 64'd8);
    check("p2 table_full", 64'(table_full), 64'd1);
    check("p2 err before drop", 64'(err_sticky), 64'd0);
    req(32'd18, 1'b0, 64'd208);
    check("p2 err after drop", 64'(err_sticky), 64'd1);
    check("p2 outstanding after drop", 64'(outstanding), 64'd8);
    req_and_resp(32'd19, 32'd10, 64'd210);
    check("p2 outstanding after free+drop", 64'(outstanding), 64'd7);
    check("p2 table_full after free", 64'(table_full), 64'd0);
    run_phase(2);
    for (int i = 1; i < 8; i++) resp(32'(10 + i), 64'd300);
    check("p2 drained", 64'(outstanding), 64'd0);

    // phase 3
    do_clear();
    check("p3 err after clear", 64'(err_sticky), 64'd0);
    resp(32'h77, 64'd400);
    check("p3 err after orphan", 64'(err_sticky), 64'd1);
    check("p3 outstanding after orphan", 64'(outstanding), 64'd0);
    req_and_resp(32'd3, 32'd3, 64'd400);
    check("p3 same-cycle outstanding", 64'(outstanding), 64'd1);
    req(32'd3, 1'b0, 64'd410);
    check("p3 dup outstanding", 64'(outstanding), 64'd2);
    resp(32'd3, 64'd420);
    resp(32'd3, 64'd425);
    check("p3 outstanding drained", 64'(outstanding), 64'd0);
    run_phase(3);

    // phase 4 and 5
    do_clear();
    req(32'h20, 1'b0, 64'd1000);
    resp(32'h20, 64'd1100);
    req(32'h21, 1'b1, 64'd2000);
    resp(32'h21, 64'd2004);
    req(32'h22, 1'b1, 64'd3000);
    resp(32'h22, 64'd3040);
    run_phase(4);
    req(32'h30, 1'b0, 64'd10);
    resp(32'h30, 64'h1_0000_000F);
    run_phase(5);

    // phase 6
    req(32'h40, 1'b0, 64'd5000);
    req(32'h41, 1'b0, 64'd5001);
    resp(32'h40, 64'd5010);
    clear = 1'b1; resp_fire = 1'b1; resp_id = 32'h99;
    step();
    clear = 1'b0; resp_fire = 1'b0;
    check("p6 outstanding kept", 64'(outstanding), 64'd1);
    check("p6 err cleared", 64'(err_sticky), 64'd0);
    run_phase(6);

    // phase 7
    req(32'h50, 1'b0, 64'd6000);
    req(32'h51, 1'b0, 64'd6001);
    check("p7 outstanding before reset", 64'(outstanding), 64'd3);
    stat_sel = 8'd4;
    step();
    check("p7 stat_data before reset", 64'(stat_data), 64'hFFFF_FFFF);
    resp(32'h50, 64'd6020);
    reset = 1'b0;
    #1;
    check("p7 async outstanding", 64'(outstanding), 64'd0);
    check("p7 async stat_data", 64'(stat_data), 64'd0);
    check("p7 async table_full", 64'(table_full), 64'd0);
    step();
    step();
    reset = 1'b1;
    resp(32'h41, 64'd7000);
    resp(32'h51, 64'd7001);
    check("p7 err after orphans", 64'(err_sticky), 64'd1);
    run_phase(7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
